// File: rtl/d_ram_writer_pkg.sv
// Shared neuron-RAM library package: layer RAM geometry, storage types,
// the writer FSM state encoding and the start-request legality check.
package d_ram_writer_pkg;

    // Layer RAM geometry shared by every block that touches the RAM.
    localparam int MAX_DEPTH   = 4;
    localparam int MAX_NEURONS = 8;
    localparam int ELEM_W      = 32;

    // One layer row and the full layer matrix as held by the RAM.
    typedef logic [MAX_NEURONS-1:0][ELEM_W-1:0] ARR;
    typedef ARR [MAX_DEPTH-1:0]                  VAL_MATRIX;

    // Writer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // A start request is legal when the layer exists and the neuron count
    // fits in one row; a zero-length layer is rejected.
    function automatic logic cfg_ok(input logic [31:0] layer,
                                    input logic [31:0] num,
                                    input int          depth,
                                    input int          maxn);
        return (layer < 32'(depth)) && (num != 32'd0) && (num <= 32'(maxn));
    endfunction

endpackage

// File: rtl/d_ram_writer.sv
// Layer RAM writer: streams num_neurons values from a valid/ready producer
// into one layer row, one registered RAM write per accepted value, then
// pulses layer_done after a one-cycle flush.
module d_ram_writer
    import d_ram_writer_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_DEPTH   = d_ram_writer_pkg::MAX_DEPTH,
    parameter int MAX_NEURONS = d_ram_writer_pkg::MAX_NEURONS
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [31:0]       layer_sel,
    input  logic [31:0]       num_neurons,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_rw,
    output logic [31:0]       ram_layer_index,
    output logic [31:0]       ram_neuron_index,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              busy,
    output logic              layer_done,
    output logic              cfg_err
);

    wr_state_e         state_q, state_d;
    logic [31:0]       cnt_q,   cnt_d;
    logic [31:0]       layer_q, layer_d;
    logic [31:0]       num_q,   num_d;
    logic              rw_q,    rw_d;
    logic [31:0]       lidx_q,  lidx_d;
    logic [31:0]       nidx_q,  nidx_d;
    logic [DATA_W-1:0] din_q,   din_d;
    logic              err_q,   err_d;

    logic xfer;
    logic last;

    // Handshake decode; the last transfer is the one at count num-1.
    always_comb begin
        in_ready = (state_q == ST_WRITE);
        xfer     = in_valid && in_ready;
        last     = (cnt_q == num_q - 32'd1);
    end

    // Next-state logic: FSM, counter, and the registered RAM port image.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        layer_d = layer_q;
        num_d   = num_q;
        rw_d    = 1'b0;
        lidx_d  = lidx_q;
        nidx_d  = nidx_q;
        din_d   = din_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok(layer_sel, num_neurons, MAX_DEPTH, MAX_NEURONS)) begin
                        state_d = ST_WRITE;
                        layer_d = layer_sel;
                        num_d   = num_neurons;
                        cnt_d   = 32'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (xfer) begin
                    rw_d   = 1'b1;
                    lidx_d = layer_q;
                    nidx_d = cnt_q;
                    din_d  = in_data;
                    cnt_d  = cnt_q + 32'd1;
                    if (last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // FLUSH covers the cycle in which the final write is on the port.
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
            num_q   <= '0;
            rw_q    <= 1'b0;
            lidx_q  <= '0;
            nidx_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            num_q   <= num_d;
            rw_q    <= rw_d;
            lidx_q  <= lidx_d;
            nidx_q  <= nidx_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // Outputs drive the layer RAM ports directly from registers.
    always_comb begin
        ram_rw           = rw_q;
        ram_layer_index  = lidx_q;
        ram_neuron_index = nidx_q;
        ram_d_in         = din_q;
        cfg_err          = err_q;
        busy             = (state_q != ST_IDLE);
        layer_done       = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_d_ram_writer.sv
// Directed bench for d_ram_writer with a behavioural layer RAM model.
module tb_d_ram_writer;
    import d_ram_writer_pkg::*;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic [31:0]   layer_sel;
    logic [31:0]   num_neurons;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          ram_rw;
    logic [31:0]   ram_layer_index;
    logic [31:0]   ram_neuron_index;
    logic [DW-1:0] ram_d_in;
    logic          busy;
    logic          layer_done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    VAL_MATRIX mem;

    d_ram_writer #(.DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .layer_sel(layer_sel),
        .num_neurons(num_neurons), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_rw(ram_rw), .ram_layer_index(ram_layer_index),
        .ram_neuron_index(ram_neuron_index), .ram_d_in(ram_d_in), .busy(busy),
        .layer_done(layer_done), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    // Layer RAM model: commits writes mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (ram_rw) begin
            wr_cnt = wr_cnt + 1;
            if (ram_layer_index < 32'(MAX_DEPTH) && ram_neuron_index < 32'(MAX_NEURONS))
                mem[int'(ram_layer_index)][int'(ram_neuron_index)] = ram_d_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one value after `gaps` idle cycles, then check the write image.
    task automatic feed(input logic [31:0] lay, input logic [31:0] idx,
                        input logic [31:0] val, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            tick();
            chk("gap_rw", ram_rw, 1'b0);
            chk("gap_hold_idx", ram_neuron_index, (idx == 0) ? 32'd0 : idx - 1);
        end
        in_valid = 1'b1;
        in_data  = val;
        tick();
        chk("wr_rw", ram_rw, 1'b1);
        chk("wr_layer", ram_layer_index, lay);
        chk("wr_idx", ram_neuron_index, idx);
        chk("wr_data", ram_d_in, val);
    endtask

    task automatic do_start(input logic [31:0] lay, input logic [31:0] n);
        start       = 1'b1;
        layer_sel   = lay;
        num_neurons = n;
        tick();
        start = 1'b0;
    endtask

    // After the last feed: FLUSH cycle is already showing; expect DONE next.
    task automatic finish_layer();
        in_valid = 1'b0;
        chk("flush_busy", busy, 1'b1);
        chk("flush_done", layer_done, 1'b0);
        tick();
        chk("done_pulse", layer_done, 1'b1);
        chk("done_rw", ram_rw, 1'b0);
        chk("done_ready", in_ready, 1'b0);
    endtask

    initial begin
        int w0;
        RST_N = 1'b0; start = 1'b0; layer_sel = '0; num_neurons = '0;
        in_valid = 1'b0; in_data = '0;
        mem = '0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rw", ram_rw, 1'b0);
        chk("rst_lidx", ram_layer_index, 32'd0);
        chk("rst_nidx", ram_neuron_index, 32'd0);
        chk("rst_din", ram_d_in, 32'd0);
        chk("rst_done", layer_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        RST_N = 1'b1;
        tick();

        // Layer 2, three values back to back.
        w0 = wr_cnt;
        do_start(2, 3);
        chk("s1_busy", busy, 1'b1);
        chk("s1_ready", in_ready, 1'b1);
        feed(2, 0, 5, 0);
        feed(2, 1, 6, 0);
        feed(2, 2, 7, 0);
        finish_layer();
        tick();
        chk("s1_idle", busy, 1'b0);
        chk("s1_done_off", layer_done, 1'b0);
        chk("s1_wcount", wr_cnt - w0, 3);
        chk("s1_mem2", mem[2][2], 32'd7);

        // Same layer with two-cycle producer stalls.
        w0 = wr_cnt;
        do_start(2, 3);
        feed(2, 0, 5, 0);
        feed(2, 1, 6, 2);
        feed(2, 2, 7, 2);
        finish_layer();
        tick();
        chk("s2_wcount", wr_cnt - w0, 3);

        // Illegal configurations are rejected.
        w0 = wr_cnt;
        do_start(MAX_DEPTH, 3);
        chk("bad_layer_err", cfg_err, 1'b1);
        chk("bad_layer_busy", busy, 1'b0);
        tick();
        chk("bad_layer_err_off", cfg_err, 1'b0);
        do_start(1, 0);
        chk("zero_n_err", cfg_err, 1'b1);
        chk("zero_n_busy", busy, 1'b0);
        do_start(1, MAX_NEURONS + 1);
        chk("big_n_err", cfg_err, 1'b1);
        chk("big_n_busy", busy, 1'b0);
        tick();
        chk("bad_wcount", wr_cnt - w0, 0);

        // Reset after the second accept of a four-value layer.
        w0 = wr_cnt;
        do_start(1, 4);
        feed(1, 0, 10, 0);
        feed(1, 1, 11, 0);
        RST_N = 1'b0; start = 1'b1; layer_sel = 0; num_neurons = 2;
        in_valid = 1'b1; in_data = 12;
        tick();
        chk("mr_rw", ram_rw, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_nidx", ram_neuron_index, 32'd0);
        chk("mr_lidx", ram_layer_index, 32'd0);
        chk("mr_din", ram_d_in, 32'd0);
        chk("mr_ready", in_ready, 1'b0);
        RST_N = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick(); tick();
        chk("mr_wcount", wr_cnt - w0, 2);
        chk("mr_kept", mem[1][1], 32'd11);

        // Start during WRITE is ignored; restart right after DONE.
        do_start(3, 2);
        start = 1'b1; layer_sel = 0; num_neurons = 5;
        feed(3, 0, 20, 0);
        start = 1'b0;
        feed(3, 1, 21, 0);
        finish_layer();
        tick();
        chk("b2b_idle", busy, 1'b0);
        do_start(0, 2);
        chk("b2b_ready", in_ready, 1'b1);
        chk("b2b_err", cfg_err, 1'b0);
        feed(0, 0, 30, 0);
        feed(0, 1, 31, 0);
        finish_layer();
        tick();

        // Full-width row.
        do_start(1, MAX_NEURONS);
        for (int i = 0; i < MAX_NEURONS; i++) feed(1, i, 100 + i, 0);
        chk("full_last_idx", ram_neuron_index, MAX_NEURONS - 1);
        finish_layer();
        tick();
        for (int i = 0; i < MAX_NEURONS; i++) chk("full_row", mem[1][i], 100 + i);
        chk("row0_0", mem[0][0], 32'd30);
        chk("row3_1", mem[3][1], 32'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_ram_writer.md
D_RAM_WRITER -- requirements
Module: d_ram_writer

Interface
REQ-001 Parameter DATA_W, default 32, width of one neuron value; matches the integer element width of the layer RAM.
REQ-002 Parameter MAX_DEPTH, default from shared package, number of layers held in the RAM.
REQ-003 Parameter MAX_NEURONS, default from shared package, neurons per layer row.
REQ-004 CLK  in  1  sole clock; all state updates on posedge.
REQ-005 RST_N  in  1  reset; synchronous and active-low.
REQ-006 start  in  1  one-cycle request to begin filling a layer; sampled only in IDLE.
REQ-007 layer_sel  in  32  target layer index, sampled with start.
REQ-008 num_neurons  in  32  neuron count to write, sampled with start.
REQ-009 in_valid  in  1  producer has a neuron value on in_data.
REQ-010 in_data  in  DATA_W  neuron value.
REQ-011 in_ready  out  1  writer accepts in_data this cycle.
REQ-012 ram_rw  out  1  RAM write strobe (1 = write, 0 = read/idle).
REQ-013 ram_layer_index  out  32  RAM layer index.
REQ-014 ram_neuron_index  out  32  RAM neuron index.
REQ-015 ram_d_in  out  DATA_W  RAM write data.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 layer_done  out  1  one-cycle pulse: layer fully written.
REQ-018 cfg_err  out  1  one-cycle pulse: start rejected.

Function
REQ-019 FSM states: IDLE, WRITE, FLUSH, DONE.
REQ-020 IDLE -> WRITE on start when 0 <= layer_sel < MAX_DEPTH and 1 <= num_neurons <= MAX_NEURONS; layer_sel and num_neurons are latched and neuron counter is cleared to 0.
REQ-021 start with an illegal layer_sel or num_neurons: cfg_err = 1 the next cycle; FSM stays IDLE; no RAM write.
REQ-022 start outside IDLE is ignored, with no error pulse.
REQ-023 in_ready = 1 only in WRITE (combinational decode of state); a transfer occurs when in_valid && in_ready.
REQ-024 For a transfer at cycle t, at t+1: ram_rw = 1, ram_neuron_index = counter value at t, ram_layer_index = latched layer, ram_d_in = in_data at t (all registered).
REQ-025 ram_rw = 0 in any cycle not following a transfer; index and data outputs hold their last values.
REQ-026 Counter increments by 1 per transfer; in_valid low stalls the counter with no write.
REQ-027 Transfer with counter == num_neurons-1: WRITE -> FLUSH; FLUSH -> DONE after one cycle; DONE -> IDLE after one cycle.
REQ-028 layer_done = 1 exactly in the DONE cycle (t+2 after the last transfer); ram_rw = 0 in that cycle.
REQ-029 Each neuron index 0..num_neurons-1 is written exactly once per layer, in ascending order; indices >= num_neurons are never written.
REQ-030 Back-to-back: start sampled in the cycle after DONE is accepted; there is no other dead cycle.

Reset
REQ-031 RST_N low at a posedge forces: state IDLE, counter 0, ram_rw 0, ram_layer_index 0, ram_neuron_index 0, ram_d_in 0, busy 0, layer_done 0, cfg_err 0.
REQ-032 Reset mid-layer abandons the layer; no further write is issued, and already-written RAM entries are not cleared.
REQ-033 RST_N has priority over start and in_valid in the same cycle.

Structure
REQ-034 MAX_DEPTH, MAX_NEURONS, ARR and VAL_MATRIX types, and the FSM state enum live in the shared library package; this block contains no local copies.
REQ-035 Single module; no sub-module.
REQ-036 Outputs connect directly to the layer RAM ports: rw, layer_index, neuron_index, d_in.

Verification
REQ-037 start(layer 2, 3 neurons), in_valid held high with data 5, 6, 7 -> writes (2,0,5), (2,1,6), (2,2,7) on consecutive cycles; layer_done 2 cycles after the third accept.
REQ-038 Same as REQ-037 with in_valid low for 2 cycles between values -> no ram_rw during the gaps; the same three writes occur.
REQ-039 start with layer_sel = MAX_DEPTH, and separately with num_neurons = 0 -> cfg_err pulse, busy stays 0, no ram_rw.
REQ-040 RST_N low after the 2nd accept of a 4-neuron layer -> all outputs at reset values the next cycle; no 3rd write.
REQ-041 start during WRITE, then a new start in the cycle after DONE -> the first start is ignored; the second layer's writes begin correctly with neuron index 0.
REQ-042 num_neurons = MAX_NEURONS -> the final write uses ram_neuron_index = MAX_NEURONS-1, and the layer RAM row read back matches the written data.
